// File: rtl/if_id_buffer_if.sv
// IF -> ID boundary bundle: fetch-side controls and SRAM data in,
// registered decode-stage instruction out.
interface if_id_buffer_if;
  logic        stall;
  logic        flush;
  logic [31:0] if_pc;
  logic [31:0] inst_sram_rdata;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic        id_adel;

  modport master (
    output stall, flush, if_pc, inst_sram_rdata,
    input  id_valid, id_pc, id_inst, id_adel
  );

  modport slave (
    input  stall, flush, if_pc, inst_sram_rdata,
    output id_valid, id_pc, id_inst, id_adel
  );
endinterface

// File: rtl/if_id_buffer.sv
// IF/ID pipeline register with a one-word instruction skid buffer.
// The synchronous SRAM output only matches if_pc on the first stalled
// cycle; after that it drifts to the next word, so that word is parked
// in hold_inst and replayed when the stall releases.
module if_id_buffer #(
  parameter logic [31:0] NOP_INST = 32'h0000_0000,
  parameter logic [31:0] RESET_PC = 32'hbfbf_fffc
) (
  input  logic           clk,
  input  logic           resetn,
  if_id_buffer_if.slave  bus
);

  logic        fetch_live_q, fetch_live_d;
  logic        hold_valid_q, hold_valid_d;
  logic [31:0] hold_inst_q,  hold_inst_d;
  logic        id_valid_q,   id_valid_d;
  logic [31:0] id_pc_q,      id_pc_d;
  logic [31:0] id_inst_q,    id_inst_d;
  logic        id_adel_q,    id_adel_d;

  logic        eligible_s;
  logic        misaligned_s;
  logic [31:0] sel_inst_s;

  assign eligible_s   = fetch_live_q && (bus.if_pc != RESET_PC);
  assign misaligned_s = (bus.if_pc[1:0] != 2'b00);
  assign sel_inst_s   = hold_valid_q ? hold_inst_q : bus.inst_sram_rdata;

  // Fetch-live flag: becomes set after the first unstalled cycle out of reset.
  always_comb begin
    fetch_live_d = fetch_live_q;
    if (!bus.stall) begin
      fetch_live_d = 1'b1;
    end else begin
      fetch_live_d = fetch_live_q;
    end
  end

  // Skid buffer: capture on the first stalled cycle, drop on flush or release.
  always_comb begin
    hold_valid_d = hold_valid_q;
    hold_inst_d  = hold_inst_q;
    if (bus.flush) begin
      hold_valid_d = 1'b0;
    end else if (bus.stall) begin
      if (!hold_valid_q) begin
        hold_valid_d = 1'b1;
        hold_inst_d  = bus.inst_sram_rdata;
      end else begin
        hold_valid_d = hold_valid_q;
      end
    end else begin
      hold_valid_d = 1'b0;
    end
  end

  // IF/ID register next state: flush beats stall, stall freezes, else load.
  always_comb begin
    id_valid_d = id_valid_q;
    id_pc_d    = id_pc_q;
    id_inst_d  = id_inst_q;
    id_adel_d  = id_adel_q;
    if (bus.flush) begin
      id_valid_d = 1'b0;
      id_pc_d    = bus.if_pc;
      id_inst_d  = NOP_INST;
      id_adel_d  = 1'b0;
    end else if (bus.stall) begin
      id_valid_d = id_valid_q;
    end else if (eligible_s) begin
      id_valid_d = 1'b1;
      id_pc_d    = bus.if_pc;
      id_adel_d  = misaligned_s;
      id_inst_d  = misaligned_s ? NOP_INST : sel_inst_s;
    end else begin
      id_valid_d = 1'b0;
      id_pc_d    = bus.if_pc;
      id_inst_d  = NOP_INST;
      id_adel_d  = 1'b0;
    end
  end

  // State flops with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      fetch_live_q <= 1'b0;
      hold_valid_q <= 1'b0;
      hold_inst_q  <= NOP_INST;
      id_valid_q   <= 1'b0;
      id_pc_q      <= RESET_PC;
      id_inst_q    <= NOP_INST;
      id_adel_q    <= 1'b0;
    end else begin
      fetch_live_q <= fetch_live_d;
      hold_valid_q <= hold_valid_d;
      hold_inst_q  <= hold_inst_d;
      id_valid_q   <= id_valid_d;
      id_pc_q      <= id_pc_d;
      id_inst_q    <= id_inst_d;
      id_adel_q    <= id_adel_d;
    end
  end

  assign bus.id_valid = id_valid_q;
  assign bus.id_pc    = id_pc_q;
  assign bus.id_inst  = id_inst_q;
  assign bus.id_adel  = id_adel_q;

endmodule

// File: tb/tb_if_id_buffer.sv
// Directed bench for if_id_buffer: reset, sequential fetch, stalls,
// flush during stall, misaligned fetch and reset during a stall.
module tb_if_id_buffer;

  localparam logic [31:0] RST_PC = 32'hbfbf_fffc;
  localparam logic [31:0] NOP    = 32'h0000_0000;

  logic clk;
  logic resetn;
  int   n_checks;
  int   n_errors;
  logic [31:0] p;

  if_id_buffer_if bus_if ();

  if_id_buffer dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value with its expected value.
  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, then sample just after the closing edge.
  task automatic step(input logic st, input logic fl, input logic [31:0] pc, input logic [31:0] rd);
    bus_if.stall           = st;
    bus_if.flush           = fl;
    bus_if.if_pc           = pc;
    bus_if.inst_sram_rdata = rd;
    @(posedge clk);
    #1;
  endtask

  task automatic check_id(input string tag, input logic v, input logic [31:0] pc,
                          input logic [31:0] inst, input logic adel);
    check_eq({tag, "_valid"}, 32'(bus_if.id_valid), 32'(v));
    check_eq({tag, "_pc"},    bus_if.id_pc,         pc);
    check_eq({tag, "_inst"},  bus_if.id_inst,       inst);
    check_eq({tag, "_adel"},  32'(bus_if.id_adel),  32'(adel));
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    resetn   = 1'b0;

    // Reset
    step(1'b0, 1'b0, RST_PC, 32'h0000_0000);
    step(1'b0, 1'b0, RST_PC, 32'h0000_0000);
    check_id("reset", 1'b0, RST_PC, NOP, 1'b0);

    // Sequential fetch after release
    resetn = 1'b1;
    step(1'b0, 1'b0, RST_PC, RST_PC);
    check_id("first_cycle", 1'b0, RST_PC, NOP, 1'b0);
    step(1'b0, 1'b0, 32'hbfc0_0000, 32'hbfc0_0000);
    check_id("seq0", 1'b1, 32'hbfc0_0000, 32'hbfc0_0000, 1'b0);
    step(1'b0, 1'b0, 32'hbfc0_0004, 32'hbfc0_0004);
    check_id("seq1", 1'b1, 32'hbfc0_0004, 32'hbfc0_0004, 1'b0);

    // Three-cycle stall with SRAM drifting to the next word
    step(1'b1, 1'b0, 32'hbfc0_0008, 32'hbfc0_0008);
    check_id("stall3_a", 1'b1, 32'hbfc0_0004, 32'hbfc0_0004, 1'b0);
    step(1'b1, 1'b0, 32'hbfc0_0008, 32'hbfc0_000c);
    check_id("stall3_b", 1'b1, 32'hbfc0_0004, 32'hbfc0_0004, 1'b0);
    step(1'b1, 1'b0, 32'hbfc0_0008, 32'hbfc0_000c);
    check_id("stall3_c", 1'b1, 32'hbfc0_0004, 32'hbfc0_0004, 1'b0);
    step(1'b0, 1'b0, 32'hbfc0_0008, 32'hbfc0_000c);
    check_id("release3", 1'b1, 32'hbfc0_0008, 32'hbfc0_0008, 1'b0);
    step(1'b0, 1'b0, 32'hbfc0_000c, 32'hbfc0_000c);
    check_id("after3", 1'b1, 32'hbfc0_000c, 32'hbfc0_000c, 1'b0);

    // Single-cycle stall every other cycle, 20 instructions
    p = 32'hbfc0_0010;
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 1'b0, p, p);
      check_eq("alt_frozen_pc", bus_if.id_pc, p - 32'd4);
      step(1'b0, 1'b0, p, p + 32'd4);
      check_eq("alt_pc",   bus_if.id_pc,   p);
      check_eq("alt_inst", bus_if.id_inst, p);
      p = p + 32'd4;
    end

    // Flush on the second cycle of a two-cycle stall
    step(1'b1, 1'b0, p, p);
    step(1'b1, 1'b1, p, p + 32'd4);
    check_id("flush", 1'b0, p, NOP, 1'b0);
    step(1'b0, 1'b0, 32'hbfc0_0100, 32'hbfc0_0100);
    check_id("post_flush", 1'b1, 32'hbfc0_0100, 32'hbfc0_0100, 1'b0);

    // Misaligned fetch, then an aligned one
    step(1'b0, 1'b0, 32'hbfc0_0002, 32'hbfc0_0002);
    check_id("adel", 1'b1, 32'hbfc0_0002, NOP, 1'b1);
    step(1'b0, 1'b0, 32'hbfc0_0104, 32'hbfc0_0104);
    check_id("aligned", 1'b1, 32'hbfc0_0104, 32'hbfc0_0104, 1'b0);

    // Reset while a word is buffered
    step(1'b1, 1'b0, 32'hbfc0_0200, 32'hbfc0_0200);
    resetn = 1'b0;
    step(1'b1, 1'b0, 32'hbfc0_0200, 32'hbfc0_0204);
    check_id("reset_stall", 1'b0, RST_PC, NOP, 1'b0);
    resetn = 1'b1;
    step(1'b0, 1'b0, RST_PC, RST_PC);
    check_id("restart_first", 1'b0, RST_PC, NOP, 1'b0);
    step(1'b0, 1'b0, 32'hbfc0_0000, 32'hbfc0_0000);
    check_id("restart0", 1'b1, 32'hbfc0_0000, 32'hbfc0_0000, 1'b0);
    step(1'b0, 1'b0, 32'hbfc0_0004, 32'hbfc0_0004);
    check_id("restart1", 1'b1, 32'hbfc0_0004, 32'hbfc0_0004, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
